// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer.
//   - state_t      : sequencer states
//   - ADDR_*       : PLL reconfig register addresses
//   - PROF_TABLE   : two clock profiles, each PROF_WORDS entries of
//                    {addr[5:0], data[31:0]}, written in index order
//   - entry_addr / entry_data : field extraction helpers for a table entry
package pll_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_WRITE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_LOCK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int PROF_WORDS = 4;
    localparam int ENTRY_W    = 38;

    // Counter data: [22:18] counter select, [17] odd division, [15:8] high
    // count, [7:0] low count.
    // Profile 0: 50 MHz / N5 * M66 = 660 MHz VCO, C0 /100 -> 6.6 MHz.
    // Profile 1: 50 MHz / N5 * M54 = 540 MHz VCO, C0 /20  -> 27 MHz.
    localparam logic [ENTRY_W-1:0] PROF_TABLE [2][PROF_WORDS] = '{
        '{ {ADDR_N, 32'h0002_0302}, {ADDR_M, 32'h0000_2121},
           {ADDR_C, 32'h0000_3232}, {ADDR_C, 32'h0004_1919} },
        '{ {ADDR_N, 32'h0002_0302}, {ADDR_M, 32'h0000_1B1B},
           {ADDR_C, 32'h0000_0A0A}, {ADDR_C, 32'h0004_0505} }
    };

    function automatic logic [5:0] entry_addr(input logic [ENTRY_W-1:0] e);
        return e[37:32];
    endfunction

    function automatic logic [31:0] entry_data(input logic [ENTRY_W-1:0] e);
        return e[31:0];
    endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL lock indication into
// the management clock domain.
//   clk  : management clock
//   rst  : synchronous active-high reset (output forced to "not locked")
//   i_d  : asynchronous input
//   o_q  : synchronized output, two clk cycles of latency
module pll_reconfig_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Run-time video clock profile switcher for the system PLL.
// Writes the selected profile into the PLL reconfig block over Avalon-MM,
// starts the reconfiguration, then waits for a stable lock.
//   clk, rst         : 50 MHz management clock, synchronous active-high reset
//   req, sel         : switch request and requested profile (sampled in idle)
//   busy             : sequence in progress
//   done             : one-cycle completion pulse
//   error            : sticky lock-timeout flag, cleared on the next accepted req
//   profile          : currently loaded profile
//   locked_in        : asynchronous PLL lock
//   mgmt_address, mgmt_writedata, mgmt_write, mgmt_waitrequest : Avalon-MM master
module pll_reconfig_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int NUM_WORDS = PROF_WORDS,
    parameter int SETTLE    = 1024,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        sel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        profile,
    input  logic        locked_in,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest
);

    localparam int               IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_WORDS - 1);
    localparam logic [15:0]      SETTLE_C  = 16'(SETTLE);
    localparam logic [15:0]      TIMEOUT_C = 16'(TIMEOUT);

    state_t r_state;
    state_t w_state_nxt;

    logic             r_sel;
    logic             r_profile;
    logic             r_error;
    logic             r_fast_done;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_settle;
    logic [15:0]      r_tout;

    logic                w_locked_s;
    logic                w_same;
    logic                w_accept;
    logic                w_xfer;
    logic [15:0]         w_settle_inc;
    logic [15:0]         w_tout_inc;
    logic                w_settle_hit;
    logic                w_tout_hit;
    logic [ENTRY_W-1:0]  w_entry;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    pll_reconfig_ctrl_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked_in),
        .o_q (w_locked_s)
    );

    // A request for the already loaded profile is answered without touching
    // the PLL, unless the last attempt failed and the PLL state is unknown.
    assign w_same       = (sel == r_profile) && !r_error;
    assign w_accept     = (r_state == ST_IDLE) && req && !w_same;
    assign w_xfer       = mgmt_write && !mgmt_waitrequest;
    assign w_settle_inc = sat_inc16(r_settle);
    assign w_tout_inc   = sat_inc16(r_tout);
    assign w_settle_hit = w_locked_s && (w_settle_inc >= SETTLE_C);
    assign w_tout_hit   = (w_tout_inc >= TIMEOUT_C);
    assign w_entry      = PROF_TABLE[r_sel][r_idx];

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_fast_done || (r_state == ST_DONE);
    assign error   = r_error;
    assign profile = r_profile;

    always_comb begin
        w_state_nxt    = r_state;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_MODE;
            end
            ST_MODE: begin
                // data 0 selects waitrequest mode in the reconfig block
                mgmt_write   = 1'b1;
                mgmt_address = ADDR_MODE;
                if (w_xfer) w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = entry_addr(w_entry);
                mgmt_writedata = entry_data(w_entry);
                if (w_xfer && (r_idx == IDX_LAST)) w_state_nxt = ST_START;
            end
            ST_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = ADDR_START;
                if (w_xfer) w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!mgmt_waitrequest) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_settle_hit)    w_state_nxt = ST_DONE;
                else if (w_tout_hit) w_state_nxt = ST_ERROR;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERROR: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_profile   <= 1'b0;
            r_error     <= 1'b0;
            r_fast_done <= 1'b0;
            r_idx       <= '0;
            r_settle    <= '0;
            r_tout      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fast_done <= (r_state == ST_IDLE) && req && w_same;

            if (w_accept) begin
                r_sel   <= sel;
                r_error <= 1'b0;
            end
            if ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_ERROR)) r_error <= 1'b1;
            if (r_state == ST_DONE) r_profile <= r_sel;

            // index returns to 0 on the last entry so the next sequence starts clean
            if ((r_state == ST_WRITE) && w_xfer)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

            // settle counts consecutive locked cycles; timeout counts all cycles
            if (r_state == ST_WAIT_LOCK) begin
                r_settle <= w_locked_s ? w_settle_inc : 16'h0;
                r_tout   <= w_tout_inc;
            end else begin
                r_settle <= '0;
                r_tout   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
`timescale 1ns/1ps
module tb_pll_reconfig_ctrl;

    localparam int NW      = 4;
    localparam int SETTLE  = 1024;
    localparam int TIMEOUT = 65535;

    logic        clk = 1'b0;
    logic        rst, req, sel, locked_in, mgmt_waitrequest;
    logic        busy, done, error, profile, mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    always #10 clk = ~clk;

    pll_reconfig_ctrl #(.NUM_WORDS(NW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .sel              (sel),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .profile          (profile),
        .locked_in        (locked_in),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_write       (mgmt_write),
        .mgmt_waitrequest (mgmt_waitrequest)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [5:0] addr; logic [31:0] data; int at; } wr_t;
    typedef struct { bit is_err; int at; } ev_t;
    wr_t wq[$];
    ev_t eq[$];

    // Reference copy of the two profiles: {N, M, C0, C1} per profile.
    logic [5:0]  t_addr [2][4] = '{'{6'h03, 6'h04, 6'h05, 6'h05}, '{6'h03, 6'h04, 6'h05, 6'h05}};
    logic [31:0] t_data [2][4] = '{'{32'h0002_0302, 32'h0000_2121, 32'h0000_3232, 32'h0004_1919},
                                   '{32'h0002_0302, 32'h0000_1B1B, 32'h0000_0A0A, 32'h0004_0505}};

    bit m_profile = 1'b0;
    bit m_error   = 1'b0;
    bit mon_en    = 1'b0;
    bit err_prev  = 1'b0;

    bit wr_plan[$];
    int lock_mode = 0;
    int glitch_c  = -100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_wr(input logic [5:0] ad, input logic [31:0] d, input int at);
        wr_t w;
        w.addr = ad; w.data = d; w.at = at;
        wq.push_back(w);
    endtask

    // PLL lock as driven on locked_in during cycle n
    function automatic bit lk(input int n);
        if (lock_mode == 2) return 1'b0;
        if ((lock_mode == 1) && (n == glitch_c)) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: pops expectations whenever the DUT presents a write or an event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mgmt_write) begin
                if (wq.size() == 0) begin
                    chk("spurious_write", 64'(mgmt_write), 64'd0);
                end else begin
                    chk("wr_addr", 64'(mgmt_address), 64'(wq[0].addr));
                    chk("wr_data", 64'(mgmt_writedata), 64'(wq[0].data));
                    if (!mgmt_waitrequest) begin
                        chk("wr_cycle", 64'(cyc), 64'(wq[0].at));
                        void'(wq.pop_front());
                    end
                end
            end
            if (done) begin
                chk("done_with_error", 64'(error), 64'd0);
                if (eq.size() == 0) chk("spurious_done", 64'(done), 64'd0);
                else begin
                    chk("done_event", 64'(cyc) * 2, 64'(eq[0].at) * 2 + 64'(eq[0].is_err));
                    void'(eq.pop_front());
                end
            end
            if (error && !err_prev) begin
                if (eq.size() == 0) chk("spurious_error", 64'(error), 64'd0);
                else begin
                    chk("error_event", 64'(cyc) * 2 + 1, 64'(eq[0].at) * 2 + 64'(eq[0].is_err));
                    void'(eq.pop_front());
                end
            end
        end
        err_prev = error;
    end

    // One switch request. stalls: random waitrequest per write and after START.
    // mode: 0 lock stable, 1 one-cycle drop at settle count 500, 2 never locks.
    // poke: issue a second req while busy, which must be ignored.
    task automatic do_switch(input bit s, input bit stalls, input int mode, input bit poke);
        int a, t, st, b, wl0, run, exp_at, end_c, k;
        bit exp_err, fast;
        ev_t ev;
        @(posedge clk); #1;
        a = cyc;
        fast = (s == m_profile) && !m_error;
        wr_plan.delete();
        lock_mode = mode;
        glitch_c  = -100;
        wl0 = 0;
        if (fast) begin
            exp_at = a + 1; exp_err = 1'b0;
        end else begin
            wr_plan.push_back(1'b0);
            t = a + 1;
            for (int i = 0; i < NW + 2; i++) begin
                st = stalls ? int'($urandom_range(0, 5)) : 0;
                repeat (st) wr_plan.push_back(1'b1);
                wr_plan.push_back(1'b0);
                if (i == 0)           exp_wr(6'h00, 32'h0, t + st);
                else if (i == NW + 1) exp_wr(6'h02, 32'h0, t + st);
                else                  exp_wr(t_addr[s][i-1], t_data[s][i-1], t + st);
                t = t + st + 1;
            end
            b = stalls ? int'($urandom_range(0, 5)) : 0;
            repeat (b) wr_plan.push_back(1'b1);
            wr_plan.push_back(1'b0);
            wl0 = t + b + 1;
            glitch_c = wl0 + 500 - 2;
            // locked_s trails locked_in by two cycles; need SETTLE in a row
            run = 0; exp_at = 0; exp_err = 1'b0;
            for (int n = wl0; n < wl0 + TIMEOUT + 1; n++) begin
                if (lk(n - 2)) run++; else run = 0;
                if (run == SETTLE) begin exp_at = n + 1; exp_err = 1'b0; break; end
                if (n - wl0 + 1 == TIMEOUT) begin exp_at = n + 1; exp_err = 1'b1; break; end
            end
            if (!exp_err) m_profile = s;
            m_error = exp_err;
        end
        ev.is_err = exp_err; ev.at = exp_at;
        eq.push_back(ev);
        end_c = exp_at + 2;
        req = 1'b1; sel = s; mgmt_waitrequest = 1'b0; locked_in = lk(a);
        while (cyc < end_c) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (poke && !fast && (cyc == wl0 + 10)) begin req = 1'b1; sel = ~s; end
            k = cyc - a;
            mgmt_waitrequest = (k < wr_plan.size()) ? wr_plan[k] : 1'b0;
            locked_in = lk(cyc);
            if (cyc == a + 1) begin
                @(negedge clk);
                chk("busy_after_req", 64'(busy), 64'(!fast));
                chk("write_after_req", 64'(mgmt_write), 64'(!fast));
                if (!fast) chk("error_cleared", 64'(error), 64'd0);
            end
        end
        @(negedge clk);
        chk("busy_end", 64'(busy), 64'd0);
        chk("profile_end", 64'(profile), 64'(m_profile));
        chk("error_end", 64'(error), 64'(m_error));
        chk("writes_missing", 64'(wq.size()), 64'd0);
        chk("events_missing", 64'(eq.size()), 64'd0);
        wq.delete(); eq.delete();
    endtask

    task automatic do_reset_mid();
        int a;
        bit s;
        @(posedge clk); #1;
        a = cyc;
        s = ~m_profile;
        req = 1'b1; sel = s; mgmt_waitrequest = 1'b0; locked_in = 1'b1;
        exp_wr(6'h00, 32'h0, a + 1);
        exp_wr(t_addr[s][0], t_data[s][0], a + 2);
        exp_wr(t_addr[s][1], t_data[s][1], a + 3);
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_write", 64'(mgmt_write), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_profile", 64'(profile), 64'd0);
        m_profile = 1'b0; m_error = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_writes", 64'(wq.size()), 64'd0);
        chk("rst_mid_idle_write", 64'(mgmt_write), 64'd0);
        wq.delete(); eq.delete();
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rs, rp;
        rst = 1'b1; req = 1'b0; sel = 1'b0; locked_in = 1'b0; mgmt_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_profile", 64'(profile), 64'd0);
        chk("rst_write", 64'(mgmt_write), 64'd0);
        chk("rst_addr", 64'(mgmt_address), 64'd0);
        chk("rst_data", 64'(mgmt_writedata), 64'd0);
        mon_en = 1'b1;
        locked_in = 1'b1;
        repeat (4) @(posedge clk);

        do_switch(1'b1, 1'b0, 0, 1'b0);   // profile 1, no stalls
        do_switch(1'b1, 1'b0, 0, 1'b0);   // same profile: immediate done
        do_switch(1'b0, 1'b1, 0, 1'b1);   // random stalls, req while busy
        do_switch(1'b1, 1'b1, 1, 1'b0);   // lock glitch
        do_reset_mid();
        do_switch(1'b1, 1'b0, 0, 1'b0);   // clean restart after reset
        do_switch(1'b0, 1'b1, 2, 1'b0);   // lock timeout
        do_switch(1'b1, 1'b0, 0, 1'b0);   // same profile after error reloads
        for (int r = 0; r < 2; r++) begin
            rs = 1'($urandom_range(0, 1));
            rp = 1'($urandom_range(0, 1));
            do_switch(rs, 1'b1, 0, rp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Sequencer that reprograms the video-clock output of the system PLL at run time through the PLL reconfiguration block's Avalon-MM management port. It switches between two stored clock profiles: profile 0 is the native 6.6 MHz pixel clock, profile 1 is the alternate video clock. For each switch it writes the profile's counter registers, triggers the reconfiguration, and qualifies the resulting lock before reporting completion. It sits between the top-level video-mode logic and the PLL reconfig IP, in the 50 MHz management clock domain.

## Interface
- NUM_WORDS, 4: register writes per profile (address/data pairs).
- SETTLE, 1024: consecutive locked cycles required before success.
- TIMEOUT, 65535: maximum cycles in WAIT_LOCK before error.
- clk  in  1  management clock (50 MHz). Single clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  1  request a profile switch; sampled only in IDLE.
- sel  in  1  profile to load; captured when req is accepted.
- busy  out  1  high from the cycle after acceptance until DONE/ERROR exits.
- done  out  1  one-cycle pulse on success.
- error  out  1  sticky lock-timeout flag; cleared by the next accepted req.
- profile  out  1  currently loaded profile.
- locked_in  in  1  PLL locked, asynchronous.
- mgmt_address  out  6  reconfig register address.
- mgmt_writedata  out  32  reconfig write data.
- mgmt_write  out  1  write strobe.
- mgmt_waitrequest  in  1  reconfig IP stall.

## Operation
- locked_in passes through a 2-flop synchronizer; only locked_s is used.
- States:
  - IDLE: on req, if sel==profile and !error, pulse done next cycle with no bus traffic and stay in IDLE. Otherwise capture sel, clear error, go to MODE.
  - MODE: write address 0x00, data 0 (waitrequest mode).
  - WRITE: write entries 0..NUM_WORDS-1 of the selected profile table in order.
  - START: write address 0x02, data 0.
  - WAIT_BUSY: hold while mgmt_waitrequest=1.
  - WAIT_LOCK: count consecutive locked_s=1 cycles; the counter resets to 0 on any locked_s=0. When the count reaches SETTLE, go to DONE. If TIMEOUT cycles elapse in this state first, go to ERROR.
  - DONE: update profile, pulse done, return to IDLE.
  - ERROR: set error, leave profile unchanged, return to IDLE.
- Bus handshake:
  - A write completes on a cycle with mgmt_write=1 and mgmt_waitrequest=0.
  - Address and data are held stable while stalled.
  - Back-to-back writes are allowed, so mgmt_write may stay high across consecutive completed transfers.
- Table index width is clog2(NUM_WORDS). The index wraps to 0 on leaving WRITE.
- req while busy is ignored and not queued.

## Timing
- Reset values: all outputs 0, profile=0 (PLL power-up config), state IDLE.
- Reset mid-sequence: mgmt_write is 0 the cycle after rst, and nothing is issued until a new req.
- Acceptance: busy rises 1 cycle after req is sampled. The first mgmt_write is in that same cycle.
- Bus phase with zero waitrequest: NUM_WORDS+2 consecutive write cycles.
- Minimum accept-to-done latency: NUM_WORDS+2 write cycles + 1 WAIT_BUSY + SETTLE + 1 DONE.
- Timeout and settle counters are 16-bit saturating.
- done and error never assert in the same cycle.

## Structure
- Shared package pll_cfg_pkg holds:
  - state enum
  - register address constants (MODE=0x00, START=0x02, M/N/C counter addresses)
  - the two profile tables as constant arrays of {addr[5:0], data[31:0]}
- Natural sub-module: sync2 (2-flop synchronizer for locked_in).

## Test plan
- Profile 1, zero waitrequest, NUM_WORDS=4:
  - Stimulus: req with sel=1 from reset.
  - Response: exactly 6 writes in order, addr 0x00, table[1][0..3], 0x02. Then, with locked_s stable, done fires SETTLE+1 cycles after waitrequest falls, and profile=1.
- Random stalls:
  - Stimulus: mgmt_waitrequest randomly high for 0-5 cycles per write.
  - Response: address and data are constant through every stall, and the write count is still 6.
- Lock glitch:
  - Stimulus: locked_s drops for 1 cycle at count 500.
  - Response: the counter restarts, and done occurs 1024 cycles after the glitch ends.
- Lock timeout:
  - Stimulus: locked_in held 0.
  - Response: error=1 after 65535 cycles in WAIT_LOCK, profile unchanged, busy=0. A next req clears error.
- Same-profile request:
  - Stimulus: req with sel=profile.
  - Response: done pulse 1 cycle later with no mgmt_write.
- Reset mid-sequence:
  - Stimulus: rst during the 3rd write.
  - Response: next cycle mgmt_write=0, busy=0, profile=0. A later req restarts cleanly.
